// File: rtl/nios32_cpu_ocimem_engine.sv
// Sysclk-domain debug memory engine: JTAG-driven monitor RAM access plus a pipelined CPU slave port.
// Optional macro NIOS32_OCIMEM_OVF_ERR_EN: MonAReg saturates at the top word and the overflow sets monitor_error.
module nios32_cpu_ocimem_engine #(
  parameter int   ADDR_W   = 8,
  parameter logic INIT_RDY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WR, RD, RDCAP} state_t;

  state_t state, state_next;

  logic [31:0]       ram [DEPTH];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;

  logic              strobe_any;
  logic              take_a;
  logic              take_b;
  logic              overrun;
  logic              addr_inc;
  logic [ADDR_W-1:0] addr_next;
  logic              ovf_err;

  logic              cpu_req;
  logic              cpu_accept;
  logic              cpu_is_csr;
  logic              cpu_wr_acc;
  logic              cpu_rd_acc;
  logic              csr_set_rdy;
  logic              csr_set_err;

  logic              rd_v1;
  logic              csr_v1;
  logic [31:0]       csr_data_v1;

  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // The CPU only gets the RAM port while the FSM is idle and no JTAG strobe is pending.
  assign cpu_req         = cpu_read | cpu_write;
  assign cpu_waitrequest = cpu_req & ((state != IDLE) | strobe_any);
  assign cpu_accept      = cpu_req & ~cpu_waitrequest;
  assign cpu_is_csr      = cpu_address[ADDR_W];
  assign cpu_wr_acc      = cpu_accept & cpu_write;
  assign cpu_rd_acc      = cpu_accept & ~cpu_write;
  assign csr_set_rdy     = cpu_wr_acc & cpu_is_csr & cpu_writedata[0];
  assign csr_set_err     = cpu_wr_acc & cpu_is_csr & cpu_writedata[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take_a     = 1'b0;
    take_b     = 1'b0;
    overrun    = 1'b0;
    addr_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          take_a  = 1'b1;
          overrun = take_action_ocimem_b | take_no_action_ocimem_a;
        end else if (take_action_ocimem_b) begin
          take_b     = 1'b1;
          overrun    = take_no_action_ocimem_a;
          state_next = WR;
        end else if (take_no_action_ocimem_a) begin
          state_next = RD;
        end
      end
      WR: begin
        addr_inc   = 1'b1;
        overrun    = strobe_any;
        state_next = IDLE;
      end
      RD: begin
        overrun    = strobe_any;
        state_next = RDCAP;
      end
      RDCAP: begin
        addr_inc   = 1'b1;
        overrun    = strobe_any;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef NIOS32_OCIMEM_OVF_ERR_EN
  logic addr_at_max;

  assign addr_at_max = (MonAReg == '1);
  assign addr_next   = addr_at_max ? MonAReg : MonAReg + ADDR_W'(1);
  assign ovf_err     = addr_inc & addr_at_max;
`else
  assign addr_next   = MonAReg + ADDR_W'(1);
  assign ovf_err     = 1'b0;
`endif

  // Single RAM port: JTAG owns it in WR/RD, the CPU everywhere else.
  assign ram_addr  = (state == IDLE) ? cpu_address[ADDR_W-1:0] : MonAReg;
  assign ram_wdata = (state == WR) ? MonDReg : cpu_writedata;
  assign ram_we    = ~reset & ((state == WR) | (cpu_wr_acc & ~cpu_is_csr));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_q <= ram[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MonAReg <= '0;
      MonDReg <= '0;
    end else begin
      if (take_a) begin
        MonAReg <= jdo[ADDR_W+1:2];
      end else if (addr_inc) begin
        MonAReg <= addr_next;
      end
      if (take_b) begin
        MonDReg <= jdo[34:3];
      end else if (state == RDCAP) begin
        MonDReg <= ram_q;
      end
    end
  end

  // A CPU set beats a JTAG clear of the same flag; any error source beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      monitor_ready <= INIT_RDY;
      monitor_error <= 1'b0;
    end else begin
      if (csr_set_rdy) begin
        monitor_ready <= 1'b1;
      end else if (take_a && jdo[35]) begin
        monitor_ready <= 1'b0;
      end
      if (csr_set_err || overrun || ovf_err) begin
        monitor_error <= 1'b1;
      end else if (take_a && jdo[34]) begin
        monitor_error <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1             <= 1'b0;
      csr_v1            <= 1'b0;
      csr_data_v1       <= '0;
      cpu_readdatavalid <= 1'b0;
      cpu_readdata      <= '0;
    end else begin
      rd_v1             <= cpu_rd_acc;
      csr_v1            <= cpu_is_csr;
      csr_data_v1       <= {30'b0, monitor_error, monitor_ready};
      cpu_readdatavalid <= rd_v1;
      if (rd_v1) begin
        cpu_readdata <= csr_v1 ? csr_data_v1 : ram_q;
      end
    end
  end

endmodule

// File: tb/tb_nios32_cpu_ocimem_engine.sv
// Randomized self-checking bench for nios32_cpu_ocimem_engine against a transaction-level model.
// Expected values follow NIOS32_OCIMEM_OVF_ERR_EN when it is defined for the build.
module tb_nios32_cpu_ocimem_engine;

  localparam int   ADDR_W   = 8;
  localparam int   DEPTH    = 1 << ADDR_W;
  localparam logic INIT_RDY = 1'b0;

  logic              clk;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W:0]   cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic              cpu_waitrequest;
  logic [31:0]       cpu_readdata;
  logic              cpu_readdatavalid;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;

  logic [31:0]       ram_m [DEPTH];
  logic [ADDR_W-1:0] mon_a;
  logic [31:0]       mon_d;
  logic              rdy_m;
  logic              err_m;
  int                checks;
  int                failures;

  nios32_cpu_ocimem_engine #(.ADDR_W(ADDR_W), .INIT_RDY(INIT_RDY)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [37:0] randJdo();
    return {6'($urandom), 32'($urandom)};
  endfunction

  // Post-access address step: wrap by default, saturate and flag with the overflow option.
  function automatic void advanceAddr();
    if (int'(mon_a) == DEPTH - 1) begin
`ifdef NIOS32_OCIMEM_OVF_ERR_EN
      err_m = 1'b1;
`else
      mon_a = '0;
`endif
    end else begin
      mon_a = mon_a + 1'b1;
    end
  endfunction

  task automatic applyStimulus(input logic sa, input logic sb, input logic sn, input logic [37:0] j);
    jdo                     = j;
    take_action_ocimem_a    = sa;
    take_action_ocimem_b    = sb;
    take_no_action_ocimem_a = sn;
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_monareg"}, 32'(MonAReg), 32'(mon_a));
    checkOutput({tag, "_ready"}, 32'(monitor_ready), 32'(rdy_m));
    checkOutput({tag, "_error"}, 32'(monitor_error), 32'(err_m));
  endtask

  task automatic jtagAddr(input logic [ADDR_W-1:0] addr, input logic clr_rdy, input logic clr_err);
    logic [37:0] j;
    j = randJdo();
    j[ADDR_W+1:2] = addr;
    j[35] = clr_rdy;
    j[34] = clr_err;
    applyStimulus(1'b1, 1'b0, 1'b0, j);
    mon_a = addr;
    if (clr_rdy) rdy_m = 1'b0;
    if (clr_err) err_m = 1'b0;
  endtask

  task automatic jtagWrite(input logic [31:0] data, input string tag);
    logic [37:0] j;
    j = randJdo();
    j[34:3] = data;
    applyStimulus(1'b0, 1'b1, 1'b0, j);
    checkOutput({tag, "_mondreg"}, MonDReg, data);
    tick();
    mon_d = data;
    ram_m[mon_a] = data;
    advanceAddr();
  endtask

  task automatic jtagRead(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, randJdo());
    tick();
    tick();
    mon_d = ram_m[mon_a];
    checkOutput({tag, "_mondreg"}, MonDReg, mon_d);
    advanceAddr();
  endtask

  task automatic cpuAccess(input logic is_wr, input logic also_rd, input logic [ADDR_W:0] addr,
                           input logic [31:0] wdata, input string tag);
    int waits;
    logic [31:0] exp;
    exp           = '0;
    cpu_address   = addr;
    cpu_writedata = wdata;
    cpu_write     = is_wr;
    cpu_read      = ~is_wr | also_rd;
    #1;
    waits = 0;
    while (cpu_waitrequest === 1'b1 && waits < 20) begin
      tick();
      #1;
      waits++;
    end
    checkOutput({tag, "_accept"}, 32'(cpu_waitrequest), 32'd0);
    if (is_wr) begin
      if (addr[ADDR_W]) begin
        if (wdata[0]) rdy_m = 1'b1;
        if (wdata[1]) err_m = 1'b1;
      end else begin
        ram_m[addr[ADDR_W-1:0]] = wdata;
      end
    end else begin
      exp = addr[ADDR_W] ? {30'b0, err_m, rdy_m} : ram_m[addr[ADDR_W-1:0]];
    end
    tick();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (!is_wr) begin
      checkOutput({tag, "_early"}, 32'(cpu_readdatavalid), 32'd0);
      tick();
      checkOutput({tag, "_valid"}, 32'(cpu_readdatavalid), 32'd1);
      checkOutput({tag, "_data"}, cpu_readdata, exp);
    end
  endtask

  initial begin
    logic [37:0] j;
    logic [31:0] d;
    int op;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    jdo      = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_address   = '0;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_writedata = '0;
    mon_a = '0;
    mon_d = '0;
    rdy_m = INIT_RDY;
    err_m = 1'b0;

    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_mondreg", MonDReg, 32'd0);
    checkOutput("rst_monareg", 32'(MonAReg), 32'd0);
    checkOutput("rst_ready", 32'(monitor_ready), 32'(INIT_RDY));
    checkOutput("rst_error", 32'(monitor_error), 32'd0);
    checkOutput("rst_rdvalid", 32'(cpu_readdatavalid), 32'd0);
    checkOutput("rst_rddata", cpu_readdata, 32'd0);
    cpuAccess(1'b0, 1'b0, {1'b1, 8'h00}, 32'd0, "rst_csr");

    $display("[TB] filling debug RAM through the CPU port");
    for (int i = 0; i < DEPTH; i++) begin
      cpuAccess(1'b1, 1'b0, {1'b0, 8'(i)}, $urandom, "fill");
    end

    $display("[TB] JTAG write then read back");
    jtagAddr(8'h10, 1'b0, 1'b0);
    checkState("addr10");
    jtagWrite(32'hDEADBEEF, "wr_dead");
    checkState("wr_dead");
    jtagAddr(8'h10, 1'b0, 1'b0);
    jtagRead("rd_dead");
    checkOutput("rd_dead_monareg", 32'(MonAReg), 32'h11);
    checkState("rd_dead");

    $display("[TB] CPU read stalled behind a JTAG read");
    jtagAddr(8'h10, 1'b0, 1'b0);
    jdo = randJdo();
    take_no_action_ocimem_a = 1'b1;
    cpu_read    = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = {1'b0, 8'h10};
    #1;
    checkOutput("arb_strobe_wait", 32'(cpu_waitrequest), 32'd1);
    tick();
    take_no_action_ocimem_a = 1'b0;
    #1;
    checkOutput("arb_rd_wait", 32'(cpu_waitrequest), 32'd1);
    tick();
    #1;
    checkOutput("arb_rdcap_wait", 32'(cpu_waitrequest), 32'd1);
    tick();
    #1;
    checkOutput("arb_idle_go", 32'(cpu_waitrequest), 32'd0);
    checkOutput("arb_mondreg", MonDReg, 32'hDEADBEEF);
    mon_d = ram_m[mon_a];
    advanceAddr();
    tick();
    cpu_read = 1'b0;
    checkOutput("arb_early", 32'(cpu_readdatavalid), 32'd0);
    tick();
    checkOutput("arb_valid", 32'(cpu_readdatavalid), 32'd1);
    checkOutput("arb_data", cpu_readdata, 32'hDEADBEEF);
    checkState("arb");

    $display("[TB] CSR flag handling");
    cpuAccess(1'b1, 1'b0, {1'b1, 8'h5A}, 32'h1, "csr_set_rdy");
    checkState("csr_set_rdy");
    jtagAddr(8'h33, 1'b1, 1'b0);
    checkState("jtag_clr_rdy");
    j = randJdo();
    j[ADDR_W+1:2] = 8'h34;
    j[35] = 1'b1;
    j[34] = 1'b0;
    jdo = j;
    take_action_ocimem_a = 1'b1;
    cpu_write     = 1'b1;
    cpu_address   = {1'b1, 8'h00};
    cpu_writedata = 32'h1;
    #1;
    checkOutput("coin_wait", 32'(cpu_waitrequest), 32'd1);
    tick();
    take_action_ocimem_a = 1'b0;
    #1;
    checkOutput("coin_go", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write = 1'b0;
    mon_a = 8'h34;
    rdy_m = 1'b1;
    checkState("coin");
    cpuAccess(1'b1, 1'b1, {1'b1, 8'hFF}, 32'h2, "csr_set_err");
    cpuAccess(1'b0, 1'b0, {1'b1, 8'h81}, 32'd0, "csr_rd");
    jtagAddr(8'h40, 1'b0, 1'b1);
    checkState("jtag_clr_err");

    $display("[TB] coincident strobes and overrun");
    j = randJdo();
    j[ADDR_W+1:2] = 8'h44;
    j[35:34] = 2'b00;
    applyStimulus(1'b1, 1'b1, 1'b0, j);
    mon_a = 8'h44;
    err_m = 1'b1;
    checkOutput("prio_ab_mondreg", MonDReg, mon_d);
    checkState("prio_ab");
    jtagAddr(8'h44, 1'b0, 1'b1);
    d = $urandom;
    j = randJdo();
    j[34:3] = d;
    applyStimulus(1'b0, 1'b1, 1'b1, j);
    tick();
    mon_d = d;
    ram_m[mon_a] = d;
    advanceAddr();
    err_m = 1'b1;
    checkOutput("prio_bn_mondreg", MonDReg, d);
    checkState("prio_bn");
    cpuAccess(1'b0, 1'b0, {1'b0, 8'h44}, 32'd0, "prio_bn_ram");
    jtagAddr(8'h60, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, randJdo());
    applyStimulus(1'b0, 1'b0, 1'b1, randJdo());
    tick();
    mon_d = ram_m[mon_a];
    advanceAddr();
    err_m = 1'b1;
    checkOutput("ovr_mondreg", MonDReg, mon_d);
    checkState("ovr");

    $display("[TB] top-of-RAM address step");
    jtagAddr(8'hFF, 1'b0, 1'b1);
    jtagWrite(32'hA5C3_0FF0, "top_wr");
    checkState("top_wr");
    cpuAccess(1'b0, 1'b0, {1'b0, 8'hFF}, 32'd0, "top_ram");
    jtagAddr(8'hFF, 1'b0, 1'b1);
    jtagRead("top_rd");
    checkState("top_rd");

    $display("[TB] reset during a JTAG write and a CPU read");
    jtagAddr(8'h20, 1'b0, 1'b0);
    j = randJdo();
    j[34:3] = ~ram_m[8'h20];
    applyStimulus(1'b0, 1'b1, 1'b0, j);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mon_a = '0;
    mon_d = '0;
    rdy_m = INIT_RDY;
    err_m = 1'b0;
    checkOutput("rstwr_mondreg", MonDReg, 32'd0);
    checkState("rstwr");
    cpuAccess(1'b0, 1'b0, {1'b0, 8'h20}, 32'd0, "rstwr_ram");
    cpu_read    = 1'b1;
    cpu_address = {1'b0, 8'h21};
    #1;
    checkOutput("rstrd_accept", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_read = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstrd_valid0", 32'(cpu_readdatavalid), 32'd0);
    tick();
    checkOutput("rstrd_valid1", 32'(cpu_readdatavalid), 32'd0);

    $display("[TB] randomized mix");
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: jtagAddr(8'($urandom), 1'($urandom), 1'($urandom));
        1: jtagWrite($urandom, "rnd_jwr");
        2: jtagRead("rnd_jrd");
        3: cpuAccess(1'b1, 1'($urandom), {1'b0, 8'($urandom)}, $urandom, "rnd_cwr");
        4: cpuAccess(1'b0, 1'b0, {($urandom_range(0, 3) == 0), 8'($urandom)}, 32'd0, "rnd_crd");
        default: cpuAccess(1'b1, 1'b0, {1'b1, 8'($urandom)}, $urandom, "rnd_csr");
      endcase
      checkState("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
